// File: rtl/control_unit_pipe.sv
// control_unit_pipe: registered ID-stage control decoder with valid/ready, stall, flush and illegal flag.
// Optional multi-cycle multiply sequencer is enabled by defining CU_MUL_EN.
module control_unit_pipe #(
  parameter int CMD_W      = 4,
  parameter int MUL_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [3:0]       op_code,
  input  logic             S_in,
  input  logic             is_mul,
  input  logic             stall_in,
  input  logic             flush_in,
  output logic             in_ready,
  output logic             out_valid,
  output logic [CMD_W-1:0] EXE_CMD,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_en,
  output logic             S_out,
  output logic             B,
  output logic             illegal,
  output logic             busy
);
  localparam int CTL_W = CMD_W + 7;
  logic [3:0]       w_cmd;
  logic             w_mr, w_mw, w_wb, w_s, w_b, w_ill, w_acc;
  logic [CTL_W-1:0] w_dec, r_ctl;
  // table decode of {mode, op_code}; mode 10 is a branch, everything unlisted is illegal
  always_comb begin
    w_cmd = 4'd0;
    w_mr  = 1'b0;
    w_mw  = 1'b0;
    w_wb  = 1'b1;
    w_s   = S_in;
    w_b   = 1'b0;
    w_ill = 1'b0;
    case ({mode, op_code})
      6'b001101: w_cmd = 4'd1;
      6'b001111: w_cmd = 4'd9;
      6'b000100: w_cmd = 4'd2;
      6'b000101: w_cmd = 4'd3;
      6'b000010: w_cmd = 4'd4;
      6'b000110: w_cmd = 4'd5;
      6'b000000: w_cmd = 4'd6;
      6'b001100: w_cmd = 4'd7;
      6'b000001: w_cmd = 4'd8;
      6'b001010: begin w_cmd = 4'd4; w_s = 1'b1; w_wb = 1'b0; end
      6'b001000: begin w_cmd = 4'd6; w_s = 1'b1; w_wb = 1'b0; end
      6'b010100: begin w_cmd = 4'd2; w_s = 1'b0; w_mr = S_in; w_mw = !S_in; w_wb = S_in; end
      default: begin
        w_b   = mode == 2'b10;
        w_ill = mode != 2'b10;
        w_wb  = mode == 2'b10;
        w_s   = mode == 2'b10 ? S_in : 1'b0;
      end
    endcase
  end
  assign w_dec = {1'b1, CMD_W'(w_cmd), w_mr, w_mw, w_wb, w_s, w_b, w_ill};
  assign {out_valid, EXE_CMD, mem_read, mem_write, wb_en, S_out, B, illegal} = r_ctl;
`ifdef CU_MUL_EN
  localparam int CNT_W = $clog2(MUL_CYCLES + 1);
  typedef enum logic {IDLE, MUL_BUSY} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mul_s, w_last;
  logic [CTL_W-1:0] w_nxt;
  logic             w_unused;
  assign w_unused = 1'b0;
  assign in_ready = !stall_in && r_state == IDLE;
  assign busy     = r_state == MUL_BUSY;
  assign w_acc    = in_valid && in_ready && !flush_in;
  assign w_last   = r_state == MUL_BUSY && r_cnt == CNT_W'(MUL_CYCLES - 1);
  // next control word: multiply issue, bubble while busy, or table decode
  always_comb begin
    w_nxt = '0;
    if (w_last)
      w_nxt = {1'b1, CMD_W'(4'd10), 3'b001, r_mul_s, 2'b00};
    else if (w_acc && is_mul && MUL_CYCLES == 1)
      w_nxt = {1'b1, CMD_W'(4'd10), 3'b001, S_in, 2'b00};
    else if (w_acc && !is_mul)
      w_nxt = w_dec;
  end
  // flush beats stall beats load; the sequencer advances only on unstalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl   <= '0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mul_s <= 1'b0;
    end else if (flush_in) begin
      r_ctl   <= '0;
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (!stall_in) begin
      r_ctl <= w_nxt;
      if (w_last) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else if (r_state == MUL_BUSY) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_acc && is_mul && MUL_CYCLES > 1) begin
        r_state <= MUL_BUSY;
        r_cnt   <= CNT_W'(1);
        r_mul_s <= S_in;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = is_mul ^ (MUL_CYCLES == 0);
  assign in_ready = !stall_in;
  assign busy     = 1'b0;
  assign w_acc    = in_valid && in_ready && !flush_in;
  // flush beats stall beats load; idle cycles turn into bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ctl <= '0;
    else if (flush_in)
      r_ctl <= '0;
    else if (!stall_in)
      r_ctl <= w_acc ? w_dec : '0;
  end
`endif
endmodule
